tuple_bits5bit_serial_tx: RTL and testbench
===========================================

// Module: tuple_bits5bit_serial_tx
// PURPOSE
//  Transmit side of the serial link that carries a Tuple(Bits[5], Bit) value between blocks.
//  - Accepts one tuple (I__0, I__1) per valid/ready handshake.
//  - Flattens it to the 6-bit word x = {I__1, I__0}, with x[4:0] = I__0 and x[5] = I__1.
//  - Shifts x out on a single wire in a UART-style frame.
//  - The matching receiver rebuilds x and splits it back into O__0 = x[4:0] and O__1 = x[5].
// PARAMETERS
//  CLKS_PER_BIT  4  CLK cycles per serial bit; legal range 1..255
//  PARITY_EN     1  1 = send an even-parity bit after the payload; 0 = no parity bit
// PORTS
//  CLK          in   1  clock; all state changes on the rising edge
//  ASYNCRESETN  in   1  asynchronous reset, active-low
//  I__0         in   5  tuple field 0 (Bits[5])
//  I__1         in   1  tuple field 1 (Bit)
//  I_valid      in   1  I__0/I__1 hold a tuple to send
//  I_ready      out  1  block can accept a tuple this cycle
//  tx           out  1  serial line; idles high
//  busy         out  1  a frame is in progress
//  frame_done   out  1  one-cycle pulse after the last stop-bit cycle
// BEHAVIOUR
//  Reset (ASYNCRESETN = 0):
//  - Takes effect immediately, with no clock edge.
//  - Outputs: tx = 1, I_ready = 1, busy = 0, frame_done = 0.
//  - FSM goes to IDLE; bit counter and clock divider are cleared.
//  - A frame in flight is aborted and is not resumed after reset.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:
//  - I_ready = 1, busy = 0, tx = 1.
//  - On an edge where I_valid & I_ready, latch shreg <= {I__1, I__0} and go to START.
//  - Inputs are sampled only at that edge and may change afterwards.
//  START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
//  DATA:
//  - Sends shreg[0] first, shifting right, so the order is x[0] .. x[5].
//  - Each bit is held for CLKS_PER_BIT cycles.
//  - After bit 5, go to PARITY if PARITY_EN, else go to STOP.
//  PARITY:
//  - tx = ^x, i.e. even parity over the 6 payload bits.
//  - The value is computed at accept time and stored.
//  - Held for CLKS_PER_BIT cycles, then go to STOP.
//  STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE; frame_done = 1 in the first IDLE cycle.
//  Registers and timing:
//  - tx is driven from a flop, with no combinational path from the inputs.
//  - I_ready and busy are decoded from the state register: I_ready = (state == IDLE), busy = !I_ready.
//  - Latency: if the handshake is on edge N, tx falls on edge N.
//  - Frame length F = (8 + PARITY_EN) * CLKS_PER_BIT cycles: 36 at default settings.
//  - Minimum handshake-to-handshake spacing is F + 1 cycles, because one IDLE cycle is mandatory.
//  Divider and counters:
//  - The divider counts 0 .. CLKS_PER_BIT-1; the bit advances when it wraps.
//  - The divider resets to 0 on every state change.
//  - The bit index is 3 bits and counts 0..5 in DATA only.
//  Edge cases:
//  - CLKS_PER_BIT = 1: one cycle per bit; no divider stall.
//  - I_valid while busy: ignored, since I_ready = 0. The source must hold its data; nothing is queued.
//  - I_valid low in IDLE: tx stays 1 indefinitely.
//  - I_valid dropping mid-frame has no effect on the frame.
//  - frame_done and a new accept may fall on the same IDLE cycle; both are honoured.
// TESTING
//  1. Reset: hold ASYNCRESETN low with no clock running -> tx=1, I_ready=1, busy=0, frame_done=0.
//  2. Default frame:
//     - Stimulus: I__0=5'h15, I__1=1 (x=6'b110101).
//     - tx, one value per 4 cycles: 0,1,0,1,0,1,1,0,1 (the parity bit is 0).
//     - busy for 36 cycles, then frame_done pulses once.
//  3. Parity check:
//     - I__0=5'h1F, I__1=0 -> payload 1,1,1,1,1,0, then parity bit 1.
//     - I__0=0, I__1=0 -> payload all zeros, then parity bit 0.
//  4. Back-to-back, I_valid held high with two tuples:
//     - The second accept happens exactly 37 cycles after the first.
//     - Changing I__0 mid-frame does not corrupt the frame in progress.
//  5. Reset during DATA bit 3 -> tx=1 immediately. After release, send 5'h0A, I__1=1 -> a clean frame.
//  6. CLKS_PER_BIT=1, PARITY_EN=0 -> frame is 8 cycles: 0,x[0..5],1. Accepts are spaced 9 cycles apart.

Source files
------------

// File: rtl/tuple_bits5bit_serial_tx.sv
// tuple_bits5bit_serial_tx
//   Serial transmitter for a Tuple(Bits[5], Bit) value. One tuple is taken per
//   valid/ready handshake, flattened to x = {I__1, I__0} and sent LSB first in a
//   UART-style frame: start(0), x[0..5], optional even parity, stop(1).
//
// Ports
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous reset, active low
//   I__0[4:0]    tuple field 0
//   I__1         tuple field 1
//   I_valid      source has a tuple to send
//   I_ready      block is idle and accepts a tuple this cycle
//   tx           serial line, idles high, registered
//   busy         frame in progress
//   frame_done   one-cycle pulse in the first idle cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for a handshake
// START  | start bit (low)
// DATA   | payload bits x[0]..x[5]
// PARITY | even-parity bit over the payload
// STOP   | stop bit (high)
module tuple_bits5bit_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [4:0] I__0,
  input  logic       I__1,
  input  logic       I_valid,
  output logic       I_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_n;
  logic [7:0] div, div_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [5:0] shreg, shreg_n;
  logic       par, par_n;
  logic       tx_n;
  logic       frame_done_n;
  logic       tick;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state      <= IDLE;
      div        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par        <= par_n;
      tx         <= tx_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    div_n        = div;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_n        = par;
    frame_done_n = 1'b0;
    tick         = (div == DIV_LAST);

    case (state)
      IDLE: begin
        div_n     = '0;
        bit_idx_n = '0;
        if (I_valid) begin
          shreg_n = {I__1, I__0};
          par_n   = ^{I__1, I__0};
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          div_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div + 8'd1;
        end
      end
      DATA: begin
        if (tick) begin
          div_n = '0;
          if (bit_idx == 3'd5) begin
            state_n = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
          end
        end else begin
          div_n = div + 8'd1;
        end
      end
      PARITY: begin
        if (tick) begin
          div_n   = '0;
          state_n = STOP;
        end else begin
          div_n = div + 8'd1;
        end
      end
      STOP: begin
        if (tick) begin
          div_n        = '0;
          state_n      = IDLE;
          frame_done_n = 1'b1;
        end else begin
          div_n = div + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase

    // tx is registered from the next state, so the line already shows the
    // start bit on the handshake edge itself.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign I_ready = (state == IDLE);
  assign busy    = !I_ready;

endmodule

// File: tb/tb_tuple_bits5bit_serial_tx.sv
// Bench for tuple_bits5bit_serial_tx. Instance 0 uses default settings
// (4 clocks/bit, parity on), instance 1 uses 1 clock/bit without parity.
// A reference model expands each accepted tuple into the list of line values
// the frame should produce, one entry per clock, and compares every cycle.
module tb_tuple_bits5bit_serial_tx;

  logic       CLK;
  logic       clk_en;
  logic       ASYNCRESETN;
  logic [4:0] d0  [2];
  logic       d1  [2];
  logic       vld [2];
  logic       rdy_w  [2];
  logic       tx_w   [2];
  logic       busy_w [2];
  logic       done_w [2];

  int n_chk;
  int n_fail;
  int cyc;

  bit exp_q   [2][$];
  bit done_m  [2];
  int acc_cnt [2];
  int last_acc[2];
  int prev_acc[2];

  tuple_bits5bit_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I__0(d0[0]), .I__1(d1[0]), .I_valid(vld[0]), .I_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  tuple_bits5bit_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I__0(d0[1]), .I__1(d1[1]), .I_valid(vld[1]), .I_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_en) CLK = ~CLK;
    end
  end

  function automatic int cpb_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit pe_of(int i);
    return (i == 0);
  endfunction

  // slot 0 = start, 1..6 = payload, 7 = parity or stop, 8 = stop
  function automatic bit frame_bit(logic [5:0] x, int slot, bit pe);
    if (slot == 0) return 1'b0;
    if (slot <= 6) return x[slot-1];
    if (slot == 7 && pe) return ^x;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Compare outputs against the model, then advance the model across the
  // coming rising edge using the inputs that will be sampled there.
  always @(negedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit exp_tx;
      bit exp_busy;
      bit dn;
      logic [5:0] x;
      if (!ASYNCRESETN) begin
        exp_q[i].delete();
        done_m[i] = 1'b0;
      end
      exp_busy = (exp_q[i].size() != 0);
      exp_tx   = exp_busy ? exp_q[i][0] : 1'b1;
      chk($sformatf("tx[%0d]", i),    32'(tx_w[i]),   32'(exp_tx));
      chk($sformatf("busy[%0d]", i),  32'(busy_w[i]), 32'(exp_busy));
      chk($sformatf("ready[%0d]", i), 32'(rdy_w[i]),  32'(!exp_busy));
      chk($sformatf("done[%0d]", i),  32'(done_w[i]), 32'(done_m[i]));
      if (ASYNCRESETN) begin
        if (rdy_w[i] && vld[i]) begin
          prev_acc[i] = last_acc[i];
          last_acc[i] = cyc;
        end
        dn = 1'b0;
        if (exp_q[i].size() != 0) begin
          void'(exp_q[i].pop_front());
          if (exp_q[i].size() == 0) dn = 1'b1;
        end else if (vld[i]) begin
          x = {d1[i], d0[i]};
          for (int s = 0; s < 8 + int'(pe_of(i)); s++)
            for (int c = 0; c < cpb_of(i); c++)
              exp_q[i].push_back(frame_bit(x, s, pe_of(i)));
          acc_cnt[i]++;
        end
        done_m[i] = dn;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int i, input logic [4:0] a, input logic b, input bit hold);
    int start;
    bit got;
    start  = acc_cnt[i];
    got    = 1'b0;
    d0[i]  = a;
    d1[i]  = b;
    vld[i] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge CLK); #1;
      if (acc_cnt[i] != start) got = 1'b1;
    end
    if (!got) chk($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
    if (!hold) vld[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    clk_en = 1'b0;
    ASYNCRESETN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d0[i] = '0; d1[i] = 1'b0; vld[i] = 1'b0;
      done_m[i] = 1'b0; acc_cnt[i] = 0; last_acc[i] = 0; prev_acc[i] = 0;
    end

    // Reset with no clock running
    #1 ASYNCRESETN = 1'b0;
    #10;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_tx[%0d]", i),    32'(tx_w[i]),   32'd1);
      chk($sformatf("rst_ready[%0d]", i), 32'(rdy_w[i]),  32'd1);
      chk($sformatf("rst_busy[%0d]", i),  32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_done[%0d]", i),  32'(done_w[i]), 32'd0);
    end
    clk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
    idle_cycles(5);

    // Default frame, then parity cases
    send(0, 5'h15, 1'b1, 1'b0);
    idle_cycles(40);
    send(0, 5'h1F, 1'b0, 1'b0);
    idle_cycles(40);
    send(0, 5'h00, 1'b0, 1'b0);
    idle_cycles(40);

    // Back-to-back with I_valid held and data changing mid-frame
    send(0, 5'h0C, 1'b1, 1'b1);
    idle_cycles(3);
    d0[0] = 5'($urandom); d1[0] = 1'($urandom);
    idle_cycles(10);
    send(0, 5'h13, 1'b0, 1'b0);
    chk("a_b2b_spacing", 32'(last_acc[0] - prev_acc[0]), 32'd37);
    idle_cycles(40);

    // Random traffic: random valid/data while busy, then real sends
    for (int n = 0; n < 6; n++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      for (int g = 0; g < gap; g++) begin
        vld[0] = 1'($urandom); d0[0] = 5'($urandom); d1[0] = 1'($urandom);
        idle_cycles(1);
      end
      send(0, 5'($urandom), 1'($urandom), 1'b0);
    end
    idle_cycles(40);

    // Reset during DATA bit 3 (x[3] = 0 so the jump to 1 is visible)
    send(0, 5'h07, 1'b1, 1'b0);
    idle_cycles(17);
    chk("a_bit3_before_rst", 32'(tx_w[0]), 32'd0);
    ASYNCRESETN = 1'b0;
    #1;
    chk("a_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("a_rst_busy", 32'(busy_w[0]), 32'd0);
    idle_cycles(2);
    ASYNCRESETN = 1'b1;
    idle_cycles(3);
    send(0, 5'h0A, 1'b1, 1'b0);
    idle_cycles(40);

    // 1 clock/bit, no parity: back-to-back frames spaced 9 cycles
    send(1, 5'($urandom), 1'($urandom), 1'b1);
    for (int n = 0; n < 4; n++) begin
      send(1, 5'($urandom), 1'($urandom), 1'b1);
      chk("b_b2b_spacing", 32'(last_acc[1] - prev_acc[1]), 32'd9);
    end
    vld[1] = 1'b0;
    idle_cycles(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
